// File: rtl/n1_sagu_seq.sv
// N1 sequential stack-bus AGU: owns PSP/RSP, runs one pipelined-Wishbone cycle per push/pull.
// Optional high-water-mark outputs are enabled by defining N1_SAGU_HWM_EN.
module n1_sagu_seq #(
   parameter int SP_WIDTH   = 12,
   parameter int PS_RS_DIST = 22
) (
   input  logic                clk_i,
   input  logic                async_rst_n_i,
   input  logic                prs2sagu_req_i,
   output logic                sagu2prs_rdy_o,
   output logic                sagu2prs_done_o,
   input  logic                prs2sagu_stack_sel_i,
   input  logic                prs2sagu_push_i,
   input  logic                prs2sagu_pull_i,
   input  logic                prs2sagu_load_i,
   input  logic                prs2sagu_psp_rst_i,
   input  logic                prs2sagu_rsp_rst_i,
   input  logic [SP_WIDTH-1:0] prs2sagu_sp_next_i,
   output logic                sbus_cyc_o,
   output logic                sbus_stb_o,
   output logic                sbus_we_o,
   output logic [SP_WIDTH-1:0] sbus_adr_o,
   output logic                sbus_tga_ps_o,
   output logic                sbus_tga_rs_o,
   input  logic                sbus_stall_i,
   input  logic                sbus_ack_i,
   output logic [SP_WIDTH-1:0] sagu_psp_o,
   output logic [SP_WIDTH-1:0] sagu_rsp_o,
   output logic                sagu2prs_lps_empty_o,
   output logic                sagu2prs_lrs_empty_o,
   output logic                sagu2excpt_psof_o,
   output logic                sagu2excpt_rsof_o,
   output logic                sagu2excpt_psuf_o,
   output logic                sagu2excpt_rsuf_o,
   input  logic                prs2sagu_excpt_clr_i
`ifdef N1_SAGU_HWM_EN
   ,
   output logic [SP_WIDTH-1:0] sagu_ps_hwm_o,
   output logic [SP_WIDTH-1:0] sagu_rs_hwm_o
`endif
);

   // state | meaning
   // IDLE  | ready for a command; bus idle
   // STB   | cyc+stb asserted, waiting for stall_i low
   // ACK   | cyc held, stb dropped, waiting for ack_i
   typedef enum logic [1:0] {S_IDLE, S_STB, S_ACK} state_t;

   localparam logic [SP_WIDTH:0]   CELLS = {1'b1, {SP_WIDTH{1'b0}}};
   localparam logic [SP_WIDTH:0]   DIST  = (SP_WIDTH+1)'(PS_RS_DIST);
   localparam logic [SP_WIDTH-1:0] ONE   = {{(SP_WIDTH-1){1'b0}}, 1'b1};

   state_t state_q, state_d;

   logic [SP_WIDTH-1:0] psp_q, rsp_q, psp_d, rsp_d, adr_q, adr_d, depth_sel;
   logic [SP_WIDTH:0]   free, load_sum;
   logic we_q, sel_q, done_q;
   logic psof_q, rsof_q, psuf_q, rsuf_q;
   logic accept, rst_any, cmd_rst, cmd_load, cmd_push, cmd_pull;
   logic load_ok, push_ok, pull_ok, bus_go, bus_fin;
   logic psof_set, rsof_set, psuf_set, rsuf_set, inst_done;

   assign accept   = prs2sagu_req_i & (state_q == S_IDLE);
   assign rst_any  = prs2sagu_psp_rst_i | prs2sagu_rsp_rst_i;
   assign cmd_rst  = accept & rst_any;
   assign cmd_load = accept & ~rst_any & prs2sagu_load_i;
   assign cmd_push = accept & ~rst_any & ~prs2sagu_load_i & prs2sagu_push_i;
   assign cmd_pull = accept & ~rst_any & ~prs2sagu_load_i & ~prs2sagu_push_i & prs2sagu_pull_i;

   // PSP+RSP never exceeds CELLS-DIST, so the subtraction cannot underflow
   assign free      = CELLS - {1'b0, psp_q} - {1'b0, rsp_q};
   assign depth_sel = prs2sagu_stack_sel_i ? rsp_q : psp_q;
   assign load_sum  = {1'b0, prs2sagu_sp_next_i}
                    + {1'b0, (prs2sagu_stack_sel_i ? psp_q : rsp_q)};
   assign load_ok   = load_sum <= (CELLS - DIST);
   assign push_ok   = free > DIST;
   assign pull_ok   = depth_sel != '0;

   assign bus_go  = (cmd_push & push_ok) | (cmd_pull & pull_ok);
   assign bus_fin = sbus_ack_i & (((state_q == S_STB) & ~sbus_stall_i) | (state_q == S_ACK));

   assign psof_set = ~prs2sagu_stack_sel_i & ((cmd_load & ~load_ok) | (cmd_push & ~push_ok));
   assign rsof_set =  prs2sagu_stack_sel_i & ((cmd_load & ~load_ok) | (cmd_push & ~push_ok));
   assign psuf_set = ~prs2sagu_stack_sel_i & cmd_pull & ~pull_ok;
   assign rsuf_set =  prs2sagu_stack_sel_i & cmd_pull & ~pull_ok;
   assign inst_done = cmd_rst | cmd_load | (cmd_push & ~push_ok) | (cmd_pull & ~pull_ok);

   always_ff @(posedge clk_i or negedge async_rst_n_i) begin
      if (!async_rst_n_i) state_q <= S_IDLE;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus_go) state_d = S_STB;
         S_STB:   if (!sbus_stall_i) state_d = sbus_ack_i ? S_IDLE : S_ACK;
         S_ACK:   if (sbus_ack_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sagu2prs_rdy_o = (state_q == S_IDLE);
      sbus_cyc_o     = (state_q != S_IDLE);
      sbus_stb_o     = (state_q == S_STB);
      sbus_we_o      = sbus_cyc_o & we_q;
      sbus_tga_ps_o  = sbus_cyc_o & ~sel_q;
      sbus_tga_rs_o  = sbus_cyc_o & sel_q;
   end

   always_comb begin
      if (cmd_push) adr_d = prs2sagu_stack_sel_i ? ~rsp_q : psp_q;
      else          adr_d = prs2sagu_stack_sel_i ? ~(rsp_q - ONE) : (psp_q - ONE);
   end

   always_comb begin
      psp_d = psp_q;
      rsp_d = rsp_q;
      if (cmd_rst) begin
         if (prs2sagu_psp_rst_i) psp_d = '0;
         if (prs2sagu_rsp_rst_i) rsp_d = '0;
      end else if (cmd_load && load_ok) begin
         if (prs2sagu_stack_sel_i) rsp_d = prs2sagu_sp_next_i;
         else                      psp_d = prs2sagu_sp_next_i;
      end else if (bus_fin) begin
         if (sel_q) rsp_d = we_q ? rsp_q + ONE : rsp_q - ONE;
         else       psp_d = we_q ? psp_q + ONE : psp_q - ONE;
      end
   end

   always_ff @(posedge clk_i or negedge async_rst_n_i) begin
      if (!async_rst_n_i) begin
         psp_q  <= '0;
         rsp_q  <= '0;
         adr_q  <= '0;
         we_q   <= 1'b0;
         sel_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         psp_q  <= psp_d;
         rsp_q  <= rsp_d;
         done_q <= inst_done | bus_fin;
         if (bus_go) begin
            adr_q <= adr_d;
            we_q  <= cmd_push;
            sel_q <= prs2sagu_stack_sel_i;
         end
      end
   end

   // a set event in the same cycle wins over the clear
   always_ff @(posedge clk_i or negedge async_rst_n_i) begin
      if (!async_rst_n_i) begin
         psof_q <= 1'b0;
         rsof_q <= 1'b0;
         psuf_q <= 1'b0;
         rsuf_q <= 1'b0;
      end else begin
         psof_q <= psof_set | (psof_q & ~prs2sagu_excpt_clr_i);
         rsof_q <= rsof_set | (rsof_q & ~prs2sagu_excpt_clr_i);
         psuf_q <= psuf_set | (psuf_q & ~prs2sagu_excpt_clr_i);
         rsuf_q <= rsuf_set | (rsuf_q & ~prs2sagu_excpt_clr_i);
      end
   end

   assign sbus_adr_o           = adr_q;
   assign sagu_psp_o           = psp_q;
   assign sagu_rsp_o           = rsp_q;
   assign sagu2prs_done_o      = done_q;
   assign sagu2prs_lps_empty_o = (psp_q == '0);
   assign sagu2prs_lrs_empty_o = (rsp_q == '0);
   assign sagu2excpt_psof_o    = psof_q;
   assign sagu2excpt_rsof_o    = rsof_q;
   assign sagu2excpt_psuf_o    = psuf_q;
   assign sagu2excpt_rsuf_o    = rsuf_q;

`ifdef N1_SAGU_HWM_EN
   logic [SP_WIDTH-1:0] ps_hwm_q, rs_hwm_q, ps_hwm_base, rs_hwm_base;

   // only an actual pointer change can raise the mark, so a clear really empties it
   always_comb begin
      ps_hwm_base = prs2sagu_excpt_clr_i ? '0 : ps_hwm_q;
      rs_hwm_base = prs2sagu_excpt_clr_i ? '0 : rs_hwm_q;
   end

   always_ff @(posedge clk_i or negedge async_rst_n_i) begin
      if (!async_rst_n_i) begin
         ps_hwm_q <= '0;
         rs_hwm_q <= '0;
      end else begin
         ps_hwm_q <= ((psp_d != psp_q) && (psp_d > ps_hwm_base)) ? psp_d : ps_hwm_base;
         rs_hwm_q <= ((rsp_d != rsp_q) && (rsp_d > rs_hwm_base)) ? rsp_d : rs_hwm_base;
      end
   end

   assign sagu_ps_hwm_o = ps_hwm_q;
   assign sagu_rs_hwm_o = rs_hwm_q;
`endif

endmodule

// File: doc/n1_sagu_seq.md
Name: n1_sagu_seq

Overview:
Sequential successor to the N1 stack bus AGU. Owns the parameter stack pointer (PSP) and return stack pointer (RSP) instead of borrowing DSP arithmetic. Runs the pipelined-Wishbone stack bus cycle for each push and pull, and enforces the PS/RS safety distance. Sits between PRS (commands) and the stack bus, and feeds EXCPT with overflow and underflow flags.

Parameters:
SP_WIDTH, 12, width of stack pointers and sbus address.
PS_RS_DIST, 22, minimum number of free cells that must remain between PS and RS.

Ports:
clk_i  in  1  system clock
async_rst_n_i  in  1  asynchronous reset, active low
prs2sagu_req_i  in  1  command request
sagu2prs_rdy_o  out  1  command accepted this cycle (high in IDLE only)
sagu2prs_done_o  out  1  one-cycle pulse when a command completes
prs2sagu_stack_sel_i  in  1  1:RS, 0:PS
prs2sagu_push_i  in  1  push (bus write)
prs2sagu_pull_i  in  1  pull (bus read)
prs2sagu_load_i  in  1  load selected pointer
prs2sagu_psp_rst_i  in  1  clear PSP
prs2sagu_rsp_rst_i  in  1  clear RSP
prs2sagu_sp_next_i  in  SP_WIDTH  load value
sbus_cyc_o  out  1  bus cycle
sbus_stb_o  out  1  strobe
sbus_we_o  out  1  1:write (push), 0:read (pull)
sbus_adr_o  out  SP_WIDTH  cell address
sbus_tga_ps_o  out  1  PS access
sbus_tga_rs_o  out  1  RS access
sbus_stall_i  in  1  slave stall
sbus_ack_i  in  1  slave acknowledge
sagu_psp_o  out  SP_WIDTH  PS depth
sagu_rsp_o  out  SP_WIDTH  RS depth
sagu2prs_lps_empty_o  out  1  PSP==0
sagu2prs_lrs_empty_o  out  1  RSP==0
sagu2excpt_psof_o  out  1  sticky PS overflow
sagu2excpt_rsof_o  out  1  sticky RS overflow
sagu2excpt_psuf_o  out  1  sticky PS underflow
sagu2excpt_rsuf_o  out  1  sticky RS underflow
prs2sagu_excpt_clr_i  in  1  clear all sticky flags

Behaviour:
- Reset: PSP=RSP=0, state IDLE, all sbus outputs 0, rdy_o=1, done_o=0, all flags 0, empty outputs 1. Async reset aborts any bus cycle; cyc_o drops immediately.
- Address map: PS cell k sits at address k and grows up. RS cell k sits at address (2^SP_WIDTH-1)-k and grows down.
- Free cells = 2^SP_WIDTH - PSP - RSP, computed SP_WIDTH+1 bits wide.
- Command priority when req_i & rdy_o: rst (both rst inputs may act in one cycle) > load > push > pull.
- Reset and load complete in 1 cycle with no bus cycle; done_o pulses on the next cycle.
- Load is refused if the new value leaves free < PS_RS_DIST. On refusal the pointer is unchanged and the of flag is set.
- Push with free <= PS_RS_DIST: no bus cycle, of flag set, done_o pulses next cycle.
- Pull with depth 0: no bus cycle, uf flag set, done_o pulses next cycle.
- Push address: PS uses PSP, RS uses ~RSP. Pull address: PS uses PSP-1, RS uses ~(RSP-1).
- FSM states:
  - IDLE: accepts a command. A legal push or pull drives cyc, stb, we, adr, tga registered and moves to STB.
  - STB: holds stb and adr while stall_i=1. On stall_i=0 it drops stb and moves to ACK. If ack_i arrives in the same cycle, it jumps directly to IDLE.
  - ACK: holds cyc until ack_i. On ack_i it drops cyc, updates the pointer (push +1, pull -1), pulses done_o and returns to IDLE.
- Pointer updates happen only on ack. The outputs sagu_psp_o and sagu_rsp_o show the old value until then.
- Command inputs are sampled only at acceptance; changes mid-cycle are ignored.
- excpt_clr_i clears all flags. A set event in the same cycle takes precedence over the clear.
- Pointers never wrap; the distance check guarantees this.

Optional Feature:
N1_SAGU_HWM_EN.
- With the macro defined: adds outputs sagu_ps_hwm_o and sagu_rs_hwm_o (SP_WIDTH each). Each holds the maximum depth reached since reset, updated in the same cycle as the pointer, and cleared only by async reset or excpt_clr_i.
- Without the macro: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset, then PS push with PSP=0 and stall=0, ack one cycle later -> adr=0x000, tga_ps=1, we=1; PSP=1 after ack; done pulses; lps_empty=0.
- RS push x2 with stall held 3 cycles on the first push -> addresses 0xFFF then 0xFFE; stb held 3 extra cycles; RSP=2.
- Load PSP=4000, RSP=74, then PS push -> free=22, no cyc, psof=1, PSP stays 4000.
- Load RSP=0, then RS pull -> no bus cycle, rsuf=1; excpt_clr_i then deasserts rsuf.
- PS pull from PSP=5 -> adr=0x004, we=0; PSP=4 only after ack; async reset asserted in ACK state -> cyc=0 immediately, PSP=0.
- With N1_SAGU_HWM_EN: push PS to 3, pull to 1 -> ps_hwm=3; excpt_clr_i -> ps_hwm=0.
